// File: rtl/burst_slave.sv
// Purpose : byte-wide memory responder for the simplified AXI-style burst bus (read + write channels).
// Latency : first read beat valid the cycle after the AR handshake; write response the cycle after WLAST.
// Backpressure: RREADY low holds the current read beat; BREADY low holds the write response.
//
// Ports:
//   clk, rst                              clock, asynchronous active-low reset
//   ARVALID/ARREADY/ARADDR/ARLEN/ARID     read address channel
//   RVALID/RREADY/RDATA/RRESP/RLAST/RID   read data channel (RRESP=1 marks an out-of-range beat)
//   AWVALID/AWREADY/AWADDR/AWID           write address channel
//   WVALID/WREADY/WDATA/WLAST             write data channel (WLAST alone ends a burst)
//   BVALID/BREADY/BRESP                   write response, BRESP = {AWID, err}
module burst_slave #(
  parameter int MEM_WORDS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ARVALID,
  input  logic [7:0] ARADDR,
  input  logic [3:0] ARLEN,
  input  logic [3:0] ARID,
  output logic       ARREADY,
  output logic       RVALID,
  input  logic       RREADY,
  output logic [7:0] RDATA,
  output logic       RRESP,
  output logic       RLAST,
  output logic [3:0] RID,
  input  logic       AWVALID,
  input  logic [7:0] AWADDR,
  input  logic [3:0] AWID,
  output logic       AWREADY,
  input  logic       WVALID,
  input  logic [7:0] WDATA,
  input  logic       WLAST,
  output logic       WREADY,
  output logic       BVALID,
  input  logic       BREADY,
  output logic [4:0] BRESP
);

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // Full 8-bit address space is declared; entries at or above MEM_WORDS are
  // never written or read, so only the implemented bytes carry real storage.
  logic [7:0] mem [256];

  r_state_t   r_state;
  logic [7:0] r_addr;
  logic [3:0] r_len;
  logic [3:0] r_id;
  logic [3:0] r_cnt;
  logic [7:0] rdata_q;
  logic       rresp_q;

  w_state_t   w_state;
  logic [7:0] w_addr;
  logic [3:0] w_id;
  logic       w_err;

  logic [7:0] rd_addr;
  logic       rd_ok;
  logic [7:0] rd_val;
  logic       wr_ok;
  logic       w_beat;

  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < 9'(MEM_WORDS);
  endfunction

  // Single read port: in idle it looks up the incoming start address, during
  // a burst it looks up the address of the beat that follows the current one.
  always_comb begin
    rd_addr = (r_state == R_IDLE) ? ARADDR : r_addr + 8'd1;
    rd_ok   = in_range(rd_addr);
    rd_val  = rd_ok ? mem[rd_addr] : 8'h00;
  end

  assign wr_ok  = in_range(w_addr);
  assign w_beat = (w_state == W_DATA) && WVALID;

  // Non-blocking write: a read of the same address on the same edge sees the old byte.
  always_ff @(posedge clk) begin
    if (w_beat && wr_ok)
      mem[w_addr] <= WDATA;
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= 8'h00;
      r_len   <= 4'h0;
      r_id    <= 4'h0;
      r_cnt   <= 4'h0;
      rdata_q <= 8'h00;
      rresp_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_state <= R_DATA;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_id    <= ARID;
            r_cnt   <= 4'h0;
            rdata_q <= rd_val;
            rresp_q <= ~rd_ok;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            if (r_cnt == r_len) begin
              r_state <= R_IDLE;
              rdata_q <= 8'h00;
              rresp_q <= 1'b0;
            end else begin
              r_addr  <= rd_addr;
              r_cnt   <= r_cnt + 4'd1;
              rdata_q <= rd_val;
              rresp_q <= ~rd_ok;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= 8'h00;
      w_id    <= 4'h0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            w_state <= W_DATA;
            w_addr  <= AWADDR;
            w_id    <= AWID;
            w_err   <= 1'b0;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            w_addr <= w_addr + 8'd1;
            if (!wr_ok)
              w_err <= 1'b1;
            if (WLAST)
              w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY)
            w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign ARREADY = (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = RVALID && (r_cnt == r_len);
  assign RID     = RVALID ? r_id : 4'h0;

  assign AWREADY = (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BRESP   = BVALID ? {w_id, w_err} : 5'h00;

endmodule

// File: doc/burst_slave.md
# burst_slave

Memory-backed responder for the team's simplified AXI-style burst bus; the read-channel and write-channel counterpart of the bus master. Accepts read bursts (address, length, ID) and returns data beats with last/response flags. Accepts write bursts (address, ID, data beats terminated by WLAST) and returns a write response. Contains a byte-wide memory with independent read and write state machines that may run concurrently.

## Interface
- MEM_WORDS, 256, number of implemented bytes (1..256); addresses >= MEM_WORDS are out of range.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ARVALID  in  1  read address valid.
- ARADDR  in  8  read burst start address.
- ARLEN  in  4  read beats minus one (0..15 -> 1..16 beats).
- ARID  in  4  read transaction ID.
- ARREADY  out  1  read address accepted when high with ARVALID.
- RVALID  out  1  read data valid.
- RREADY  in  1  master accepts read beat.
- RDATA  out  8  read data.
- RRESP  out  1  0 = OK, 1 = out-of-range beat.
- RLAST  out  1  final beat of read burst.
- RID  out  4  ID of current read burst.
- AWVALID  in  1  write address valid.
- AWADDR  in  8  write burst start address.
- AWID  in  4  write transaction ID.
- AWREADY  out  1  write address accepted when high with AWVALID.
- WVALID  in  1  write data valid.
- WDATA  in  8  write data.
- WLAST  in  1  final write beat.
- WREADY  out  1  write beat accepted when high with WVALID.
- BVALID  out  1  write response valid.
- BREADY  in  1  master accepts response.
- BRESP  out  5  {AWID[3:0], err}; err = 1 if any beat of the burst was out of range.

## Operation
- Read FSM: R_IDLE -> R_DATA on ARVALID&&ARREADY; R_DATA -> R_IDLE on RVALID&&RREADY&&RLAST.
- Write FSM: W_IDLE -> W_DATA on AWVALID&&AWREADY; W_DATA -> W_RESP on WVALID&&WREADY&&WLAST; W_RESP -> W_IDLE on BVALID&&BREADY.
- ARREADY = (read state == R_IDLE); AWREADY = (write state == W_IDLE); WREADY = (write state == W_DATA). All three are state decodes.
- AR handshake latches ARADDR, ARLEN, ARID; beat counter cleared. RDATA/RRESP registered: on AR handshake load mem[ARADDR]; on each accepted beat load the next address.
- Address increments by 1 per accepted beat, 8-bit wrap (255 -> 0). Beat k (0-based) of a burst uses start+k mod 256.
- RLAST = RVALID && (beat counter == latched ARLEN). RID = latched ARID while RVALID.
- Out-of-range read beat: RDATA = 0, RRESP = 1; burst continues to full length.
- Each accepted write beat writes WDATA to the current address, then increments it. Out-of-range beat: write discarded, sticky err set. Bursts have no length limit; WLAST alone ends them.
- BRESP = {latched AWID, err}, held while BVALID; err cleared on next AW handshake.
- Same-cycle write and read of one address: read returns pre-write data (read-before-write).
- Memory contents are not cleared by reset; reads of never-written in-range bytes are undefined.

## Timing
- Reset (rst low, asynchronous): both FSMs idle; ARREADY=1, AWREADY=1, WREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0, BVALID=0, BRESP=0. In-flight bursts are abandoned. Beats already written remain in memory.
- Read latency: AR handshake at edge N -> RVALID=1 with first beat after edge N. While RREADY stays high, one beat per cycle. RREADY low holds RDATA/RRESP/RLAST stable.
- After the last read beat is accepted at edge M, ARREADY=1 after edge M. The next AR handshake occurs at edge M+1 at the earliest.
- Write: AW handshake at edge N -> WREADY=1 after N. Last beat at edge M -> WREADY=0, BVALID=1 after M. Response accepted at edge P -> AWREADY=1 after P.
- WVALID in W_IDLE or W_RESP is ignored. AWVALID/ARVALID outside idle are ignored (not latched).

## Test plan
- Reset mid-read: ARADDR=0x10, ARLEN=3 accepted; rst low during beat 1 -> RVALID=0, ARREADY=1 immediately; new burst works normally afterwards.
- Write burst: AWADDR=0x20, AWID=5, data 0xA1,0xA2,0xA3 (WLAST on third) -> BVALID one cycle after the last beat, BRESP=0x0A; read 0x20 with ARLEN=2, ARID=9 -> 0xA1,0xA2,0xA3, RRESP=0, RID=9, RLAST only on the third beat.
- Wrap: write 0x11,0x22 at AWADDR=0xFF -> mem[0xFF]=0x11, mem[0x00]=0x22; read ARADDR=0xFF, ARLEN=1 returns the same values.
- Back-pressure: 4-beat read with RREADY toggling 1,0,0,1,1,0,1 -> exactly 4 beats, outputs stable while RREADY=0; BREADY held low 3 cycles -> BVALID and BRESP held.
- MEM_WORDS=64: write 3 beats from 0x3F -> BRESP err=1, only mem[0x3F] changed; read ARADDR=0x3E, ARLEN=2 -> RRESP 0,0,1 and RDATA on beat 2 = 0.
- Concurrency: write 0x55 to 0x40 on the same edge that read beat 0 of 0x40 is loaded -> read returns old value; a subsequent read returns 0x55.
